dmem_bus_unit: RTL

//  MEM-stage data-memory bus unit between the pipelined datapath (DAD/DDT/WRITE/mreq_M) and the external data bus.

---
 rtl/dmem_bus_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/dmem_bus_unit.sv
// MEM-stage data-memory bus unit: registers each access, drives a req/ack bus with wait states,
// stalls the pipeline and returns right-aligned load data. Optional feature macro: MISALIGN_TRAP_EN.
module dmem_bus_unit #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mreq,
    input  logic        write,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        timeout,
    output logic        fault
);

    localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'((TIMEOUT_CYC == 0) ? 32'd0 : TIMEOUT_CYC - 1);
    localparam bit TimeoutEn = (TIMEOUT_CYC != 0);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q;
    logic [1:0]      off_q;
    logic [3:0]      be_n;
    logic [31:0]     wd_n;
    logic [1:0]      aoff_n;
    logic            expired;
    logic            trap;

    // Lane generation; misaligned half/word accesses collapse onto their aligned offset.
    always_comb begin
        be_n   = 4'b1111;
        wd_n   = wdata;
        aoff_n = 2'b00;
        case (size)
            2'b00: begin
                be_n   = 4'b0001 << addr[1:0];
                wd_n   = {4{wdata[7:0]}};
                aoff_n = addr[1:0];
            end
            2'b01: begin
                be_n   = 4'b0011 << {addr[1], 1'b0};
                wd_n   = {2{wdata[15:0]}};
                aoff_n = {addr[1], 1'b0};
            end
            default: ;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic fault_q;
    assign trap  = mreq & (((size == 2'b01) & addr[0]) | (size[1] & (addr[1:0] != 2'b00)));
    assign fault = fault_q;
`else
    assign trap  = 1'b0;
    assign fault = 1'b0;
`endif

    assign expired = TimeoutEn && (cnt_q == CntMax);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (mreq) state_d = trap ? StDone : StBusy;
            StBusy: if (bus_ack || expired) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Gated by rst so the pipeline is released the moment reset is asserted.
    always_comb begin
        stall = ~rst & (((state_q == StIdle) & mreq) | (state_q == StBusy));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            off_q     <= 2'b00;
            rdata     <= 32'h0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0;
            bus_be    <= 4'h0;
            bus_wdata <= 32'h0;
            timeout   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            fault_q   <= 1'b0;
`endif
        end else begin
`ifdef MISALIGN_TRAP_EN
            fault_q <= 1'b0;
`endif
            case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (mreq) begin
                        if (trap) begin
                            rdata <= 32'h0;
`ifdef MISALIGN_TRAP_EN
                            fault_q <= 1'b1;
`endif
                        end else begin
                            bus_req   <= 1'b1;
                            bus_we    <= write;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_be    <= be_n;
                            bus_wdata <= wd_n;
                            off_q     <= aoff_n;
                        end
                    end
                end
                StBusy: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (bus_ack) begin
                        rdata   <= bus_we ? 32'h0 : (bus_rdata >> {off_q, 3'b000});
                        bus_req <= 1'b0;
                    end else if (expired) begin
                        rdata   <= 32'h0;
                        bus_req <= 1'b0;
                        timeout <= 1'b1;
                    end
                end
                default: cnt_q <= '0;
            endcase
        end
    end

endmodule
